// File: rtl/inst_fetcher.sv
// Instruction-fetch front end.
// Owns the architectural fetch PC, issues one word read at a time to the
// memory controller, and presents each returned word with its address to the
// decoder. The decoder answers combinationally with _next_pc/_stall; the ROB
// can flush (_clear) or redirect (_br_rob) the fetch stream.
module inst_fetcher #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        _clear,
    input  logic        _br_rob,
    input  logic        _stall,
    input  logic [31:0] _next_pc,
    input  logic        _issue_full,
    output logic        _mem_req,
    output logic [31:0] _mem_addr,
    input  logic        _mem_ready,
    input  logic [31:0] _mem_data,
    output logic [31:0] _inst_out,
    output logic        _inst_ready_out,
    output logic [31:0] _inst_addr
);

    // FETCH   : launch a read for pc
    // WAIT    : read outstanding, response will be presented
    // HOLD    : instruction presented to the decoder
    // STALL   : JALR consumed, waiting for the ROB to resolve the target
    // DISCARD : read outstanding but flushed, response will be dropped
    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_WAIT    = 3'd1,
        S_HOLD    = 3'd2,
        S_STALL   = 3'd3,
        S_DISCARD = 3'd4
    } state_t;

    state_t      state_q,     state_d;
    logic [31:0] pc_q,        pc_d;
    logic        mem_req_q,   mem_req_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [31:0] inst_q,      inst_d;
    logic        inst_vld_q,  inst_vld_d;
    logic [31:0] inst_addr_q, inst_addr_d;

    // State and output registers; rdy_in low freezes everything.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= 32'h0;
            inst_q      <= 32'h0;
            inst_vld_q  <= 1'b0;
            inst_addr_q <= 32'h0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            inst_q      <= inst_d;
            inst_vld_q  <= inst_vld_d;
            inst_addr_q <= inst_addr_d;
        end
    end

    // Next-state and registered-output logic; a flush overrides everything.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        inst_d      = inst_q;
        inst_vld_d  = inst_vld_q;
        inst_addr_d = inst_addr_q;

        if (_clear) begin
            // Flush: redirect pc and withdraw any presented instruction.
            pc_d       = _next_pc;
            inst_vld_d = 1'b0;
            case (state_q)
                S_WAIT, S_DISCARD: begin
                    // A read is outstanding; the handshake must complete
                    // before a new request may be issued.
                    if (_mem_ready) begin
                        mem_req_d = 1'b0;
                        state_d   = S_FETCH;
                    end else begin
                        state_d   = S_DISCARD;
                    end
                end
                default: begin
                    mem_req_d = 1'b0;
                    state_d   = S_FETCH;
                end
            endcase
        end else begin
            case (state_q)
                S_FETCH: begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = {pc_q[31:2], 2'b00};
                    state_d    = S_WAIT;
                end
                S_WAIT: begin
                    if (_mem_ready) begin
                        inst_d      = _mem_data;
                        inst_addr_d = pc_q;
                        inst_vld_d  = 1'b1;
                        mem_req_d   = 1'b0;
                        state_d     = S_HOLD;
                    end
                end
                S_HOLD: begin
                    // Dispatch accepted the instruction this cycle.
                    if (!_issue_full) begin
                        inst_vld_d = 1'b0;
                        if (_stall) begin
                            state_d = S_STALL;
                        end else begin
                            pc_d    = _next_pc;
                            state_d = S_FETCH;
                        end
                    end
                end
                S_STALL: begin
                    // The decoder routes the resolved target onto _next_pc.
                    if (_br_rob) begin
                        pc_d    = _next_pc;
                        state_d = S_FETCH;
                    end
                end
                S_DISCARD: begin
                    if (_mem_ready) begin
                        mem_req_d = 1'b0;
                        state_d   = S_FETCH;
                    end
                end
                default: begin
                    mem_req_d = 1'b0;
                    state_d   = S_FETCH;
                end
            endcase
        end
    end

    assign _mem_req        = mem_req_q;
    assign _mem_addr       = mem_addr_q;
    assign _inst_out       = inst_q;
    assign _inst_ready_out = inst_vld_q;
    assign _inst_addr      = inst_addr_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher: each task walks one scenario cycle by
// cycle, acting as memory controller, decoder, dispatch and ROB.
module tb_inst_fetcher;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        _clear;
    logic        _br_rob;
    logic        _stall;
    logic [31:0] _next_pc;
    logic        _issue_full;
    logic        _mem_req;
    logic [31:0] _mem_addr;
    logic        _mem_ready;
    logic [31:0] _mem_data;
    logic [31:0] _inst_out;
    logic        _inst_ready_out;
    logic [31:0] _inst_addr;

    int checks = 0;
    int fails  = 0;

    inst_fetcher #(.RESET_PC(32'h0000_0000)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        ._clear         (_clear),
        ._br_rob        (_br_rob),
        ._stall         (_stall),
        ._next_pc       (_next_pc),
        ._issue_full    (_issue_full),
        ._mem_req       (_mem_req),
        ._mem_addr      (_mem_addr),
        ._mem_ready     (_mem_ready),
        ._mem_data      (_mem_data),
        ._inst_out      (_inst_out),
        ._inst_ready_out(_inst_ready_out),
        ._inst_addr     (_inst_addr)
    );

    always #5 clk_in = ~clk_in;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Memory response pulse for exactly one edge.
    task automatic mem_respond(input logic [31:0] data);
        _mem_ready = 1'b1;
        _mem_data  = data;
        tick();
        _mem_ready = 1'b0;
        _mem_data  = 32'h0;
        $display("mem response data=%08h  req=%0b inst_vld=%0b inst=%08h addr=%08h",
                 data, _mem_req, _inst_ready_out, _inst_out, _inst_addr);
    endtask

    task automatic test_reset();
        rst_in = 1'b0; rdy_in = 1'b1; _clear = 1'b0; _br_rob = 1'b0; _stall = 1'b0;
        _next_pc = 32'h0; _issue_full = 1'b0; _mem_ready = 1'b0; _mem_data = 32'h0;
        tick(); tick();
        checks++; if (_mem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %0b want 0", _mem_req); end
        checks++; if (_mem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %08h want 0", _mem_addr); end
        checks++; if (_inst_out !== 32'h0) begin fails++; $display("FAIL reset_inst: got %08h want 0", _inst_out); end
        checks++; if (_inst_ready_out !== 1'b0) begin fails++; $display("FAIL reset_vld: got %0b want 0", _inst_ready_out); end
        checks++; if (_inst_addr !== 32'h0) begin fails++; $display("FAIL reset_iaddr: got %08h want 0", _inst_addr); end
        $display("reset checked");
        rst_in = 1'b1;
    endtask

    task automatic test_basic_fetch();
        _next_pc = 32'h4;
        tick();
        checks++; if (_mem_req !== 1'b1) begin fails++; $display("FAIL basic_req: got %0b want 1", _mem_req); end
        checks++; if (_mem_addr !== 32'h0) begin fails++; $display("FAIL basic_addr: got %08h want 0", _mem_addr); end
        tick();
        checks++; if (_mem_req !== 1'b1 || _inst_ready_out !== 1'b0) begin fails++; $display("FAIL basic_wait: got req=%0b vld=%0b want req=1 vld=0", _mem_req, _inst_ready_out); end
        mem_respond(32'h0000_0013);
        checks++; if (_inst_out !== 32'h13) begin fails++; $display("FAIL basic_inst: got %08h want 00000013", _inst_out); end
        checks++; if (_inst_addr !== 32'h0) begin fails++; $display("FAIL basic_iaddr: got %08h want 0", _inst_addr); end
        checks++; if (_inst_ready_out !== 1'b1) begin fails++; $display("FAIL basic_vld: got %0b want 1", _inst_ready_out); end
        checks++; if (_mem_req !== 1'b0) begin fails++; $display("FAIL basic_req_drop: got %0b want 0", _mem_req); end
        tick();
        checks++; if (_inst_ready_out !== 1'b0) begin fails++; $display("FAIL basic_vld_fall: got %0b want 0", _inst_ready_out); end
        checks++; if (_mem_req !== 1'b0) begin fails++; $display("FAIL basic_fetch_gap: got %0b want 0", _mem_req); end
        tick();
        checks++; if (_mem_req !== 1'b1 || _mem_addr !== 32'h4) begin fails++; $display("FAIL basic_next: got req=%0b addr=%08h want req=1 addr=00000004", _mem_req, _mem_addr); end
    endtask

    task automatic test_backpressure();
        _issue_full = 1'b1;
        _next_pc    = 32'h8;
        mem_respond(32'h00A0_0093);
        for (int i = 0; i < 5; i++) begin
            checks++; if (_inst_ready_out !== 1'b1 || _inst_out !== 32'h00A0_0093 || _inst_addr !== 32'h4 || _mem_req !== 1'b0)
                begin fails++; $display("FAIL bp_hold[%0d]: got vld=%0b inst=%08h addr=%08h req=%0b want vld=1 inst=00a00093 addr=00000004 req=0", i, _inst_ready_out, _inst_out, _inst_addr, _mem_req); end
            tick();
        end
        _issue_full = 1'b0;
        tick();
        checks++; if (_inst_ready_out !== 1'b0) begin fails++; $display("FAIL bp_release: got %0b want 0", _inst_ready_out); end
        tick();
        checks++; if (_mem_req !== 1'b1 || _mem_addr !== 32'h8) begin fails++; $display("FAIL bp_next: got req=%0b addr=%08h want req=1 addr=00000008", _mem_req, _mem_addr); end
    endtask

    task automatic test_jalr_stall();
        mem_respond(32'h0000_80E7);
        checks++; if (_inst_out !== 32'h0000_80E7 || _inst_addr !== 32'h8) begin fails++; $display("FAIL jalr_present: got inst=%08h addr=%08h want 000080e7/00000008", _inst_out, _inst_addr); end
        _stall   = 1'b1;
        _next_pc = 32'hC;
        tick();
        _stall = 1'b0;
        checks++; if (_inst_ready_out !== 1'b0) begin fails++; $display("FAIL jalr_consume: got %0b want 0", _inst_ready_out); end
        for (int i = 0; i < 10; i++) begin
            // A stray response while nothing is outstanding must be ignored.
            if (i == 3) begin
                mem_respond(32'h1234_5678);
            end else begin
                tick();
            end
            checks++; if (_mem_req !== 1'b0 || _inst_ready_out !== 1'b0) begin fails++; $display("FAIL stall_idle[%0d]: got req=%0b vld=%0b want 0/0", i, _mem_req, _inst_ready_out); end
        end
        _br_rob  = 1'b1;
        _next_pc = 32'h1000;
        tick();
        _br_rob  = 1'b0;
        _next_pc = 32'h1004;
        checks++; if (_mem_req !== 1'b0) begin fails++; $display("FAIL stall_exit: got %0b want 0", _mem_req); end
        tick();
        checks++; if (_mem_req !== 1'b1 || _mem_addr !== 32'h1000) begin fails++; $display("FAIL stall_target: got req=%0b addr=%08h want req=1 addr=00001000", _mem_req, _mem_addr); end
    endtask

    task automatic test_clear_discard();
        _clear   = 1'b1;
        _next_pc = 32'h200;
        tick();
        _clear   = 1'b0;
        _next_pc = 32'h204;
        for (int i = 0; i < 2; i++) begin
            checks++; if (_mem_req !== 1'b1 || _mem_addr !== 32'h1000) begin fails++; $display("FAIL discard_hold[%0d]: got req=%0b addr=%08h want req=1 addr=00001000", i, _mem_req, _mem_addr); end
            tick();
        end
        mem_respond(32'hDEAD_BEEF);
        checks++; if (_mem_req !== 1'b0 || _inst_ready_out !== 1'b0) begin fails++; $display("FAIL discard_drop: got req=%0b vld=%0b want 0/0", _mem_req, _inst_ready_out); end
        checks++; if (_inst_out === 32'hDEAD_BEEF) begin fails++; $display("FAIL discard_data: got %08h want not deadbeef", _inst_out); end
        tick();
        checks++; if (_mem_req !== 1'b1 || _mem_addr !== 32'h200) begin fails++; $display("FAIL discard_next: got req=%0b addr=%08h want req=1 addr=00000200", _mem_req, _mem_addr); end
    endtask

    task automatic test_clear_consume();
        mem_respond(32'h0000_0013);
        checks++; if (_inst_ready_out !== 1'b1 || _inst_addr !== 32'h200) begin fails++; $display("FAIL cc_present: got vld=%0b addr=%08h want 1/00000200", _inst_ready_out, _inst_addr); end
        _issue_full = 1'b0;
        _clear      = 1'b1;
        _next_pc    = 32'h80;
        tick();
        _clear   = 1'b0;
        _next_pc = 32'h204;
        checks++; if (_inst_ready_out !== 1'b0 || _mem_req !== 1'b0) begin fails++; $display("FAIL cc_fall: got vld=%0b req=%0b want 0/0", _inst_ready_out, _mem_req); end
        tick();
        checks++; if (_mem_req !== 1'b1 || _mem_addr !== 32'h80) begin fails++; $display("FAIL cc_next: got req=%0b addr=%08h want req=1 addr=00000080", _mem_req, _mem_addr); end
    endtask

    task automatic test_clear_with_ready();
        _clear     = 1'b1;
        _next_pc   = 32'h300;
        _mem_ready = 1'b1;
        _mem_data  = 32'h0000_0055;
        tick();
        _clear = 1'b0; _mem_ready = 1'b0; _mem_data = 32'h0; _next_pc = 32'h304;
        checks++; if (_mem_req !== 1'b0 || _inst_ready_out !== 1'b0) begin fails++; $display("FAIL cwr_drop: got req=%0b vld=%0b want 0/0", _mem_req, _inst_ready_out); end
        checks++; if (_inst_out !== 32'h13) begin fails++; $display("FAIL cwr_data: got %08h want 00000013", _inst_out); end
        tick();
        checks++; if (_mem_req !== 1'b1 || _mem_addr !== 32'h300) begin fails++; $display("FAIL cwr_next: got req=%0b addr=%08h want req=1 addr=00000300", _mem_req, _mem_addr); end
    endtask

    task automatic test_rdy_and_async_reset();
        rdy_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                mem_respond(32'hAAAA_AAAA);
            end else begin
                tick();
            end
            checks++; if (_mem_req !== 1'b1 || _mem_addr !== 32'h300 || _inst_ready_out !== 1'b0) begin fails++; $display("FAIL pause[%0d]: got req=%0b addr=%08h vld=%0b want 1/00000300/0", i, _mem_req, _mem_addr, _inst_ready_out); end
        end
        rdy_in = 1'b1;
        tick();
        checks++; if (_mem_req !== 1'b1 || _mem_addr !== 32'h300 || _inst_ready_out !== 1'b0) begin fails++; $display("FAIL resume_wait: got req=%0b addr=%08h vld=%0b want 1/00000300/0", _mem_req, _mem_addr, _inst_ready_out); end
        #2;
        rst_in = 1'b0;
        #1;
        checks++; if (_mem_req !== 1'b0 || _mem_addr !== 32'h0 || _inst_ready_out !== 1'b0) begin fails++; $display("FAIL async_reset: got req=%0b addr=%08h vld=%0b want 0/0/0", _mem_req, _mem_addr, _inst_ready_out); end
        checks++; if (_inst_out !== 32'h0 || _inst_addr !== 32'h0) begin fails++; $display("FAIL async_reset_inst: got inst=%08h addr=%08h want 0/0", _inst_out, _inst_addr); end
        tick();
        rst_in = 1'b1;
        tick();
        checks++; if (_mem_req !== 1'b1 || _mem_addr !== 32'h0) begin fails++; $display("FAIL reset_pc: got req=%0b addr=%08h want req=1 addr=00000000", _mem_req, _mem_addr); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_jalr_stall();
        test_clear_discard();
        test_clear_consume();
        test_clear_with_ready();
        test_rdy_and_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
